case_mux6_reg: RTL and testbench

- Registered 6-to-1 data selector. A 3-bit select chooses one of six equal-width data words.
- The choice is made with a full case decode and captured in an output register.
- Select codes 6 and 7 are out of range: they yield an all-zero word and raise an error flag.
- Used as a generic datapath steering element wherever a clocked, glitch-free selected word is needed.

---
 rtl/case_mux6_reg.sv | 76 +++++++
 tb/tb_case_mux6_reg.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/case_mux6_reg.sv
// case_mux6_reg: registered 6-to-1 word selector.
// sel 0..5 steers data0..data5 into a registered out. sel 6/7 load
// an all-zero word and raise sel_err. Clearing en freezes all outputs.
module case_mux6_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic [WIDTH-1:0] data4,
  input  logic [WIDTH-1:0] data5,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             sel_err
);

  logic [WIDTH-1:0] word_dec;
  logic             in_range;

  logic [WIDTH-1:0] out_d, out_q;
  logic             out_valid_d, out_valid_q;
  logic             sel_err_d, sel_err_q;

  // Full decode of sel; codes 6 and 7 fall to the default zero word.
  always_comb begin
    word_dec = '0;
    in_range = 1'b1;
    case (sel)
      3'd0:    word_dec = data0;
      3'd1:    word_dec = data1;
      3'd2:    word_dec = data2;
      3'd3:    word_dec = data3;
      3'd4:    word_dec = data4;
      3'd5:    word_dec = data5;
      default: begin
        word_dec = '0;
        in_range = 1'b0;
      end
    endcase
  end

  // Next state: capture the decoded word and flags when enabled, else hold.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    if (en) begin
      out_d       = word_dec;
      out_valid_d = in_range;
      sel_err_d   = ~in_range;
    end
  end

  // Output register; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_case_mux6_reg.sv
// tb_case_mux6_reg: directed vectors with hand-computed expectations.
module tb_case_mux6_reg;
  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [2:0]       sel;
  logic [WIDTH-1:0] data0, data1, data2, data3, data4, data5;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             sel_err;

  int checks;
  int failures;

  case_mux6_reg #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sel      (sel),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .data3    (data3),
    .data4    (data4),
    .data5    (data5),
    .out      (out),
    .out_valid(out_valid),
    .sel_err  (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [WIDTH-1:0] e_out,
                         input logic e_vld, input logic e_err);
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_vld));
    chk({tag, ".sel_err"}, 32'(sel_err), 32'(e_err));
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [WIDTH-1:0] d0, d1, d2, d3, d4, d5);
    data0 = d0; data1 = d1; data2 = d2; data3 = d3; data4 = d4; data5 = d5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    en = 1'b0;
    sel = 3'd0;
    set_data(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);

    // Reset state, and held across edges while rst_n low
    #2;
    chk_all("rst_init", 4'd0, 1'b0, 1'b0);
    en = 1'b1;
    sel = 3'd5;
    step();
    step();
    chk_all("rst_hold", 4'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    // Sweep valid selects
    sel = 3'd0; step(); chk_all("sel0", 4'd0, 1'b1, 1'b0);
    sel = 3'd2; step(); chk_all("sel2", 4'd2, 1'b1, 1'b0);
    sel = 3'd4; step(); chk_all("sel4", 4'd4, 1'b1, 1'b0);
    sel = 3'd1; step(); chk_all("sel1", 4'd1, 1'b1, 1'b0);
    sel = 3'd3; step(); chk_all("sel3", 4'd3, 1'b1, 1'b0);
    sel = 3'd5; step(); chk_all("sel5", 4'd5, 1'b1, 1'b0);

    // Out-of-range selects with all data = F
    set_data(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
    sel = 3'd6; step(); chk_all("sel6", 4'd0, 1'b0, 1'b1);
    sel = 3'd7; step(); chk_all("sel7", 4'd0, 1'b0, 1'b1);
    sel = 3'd5; step(); chk_all("sel5_F", 4'hF, 1'b1, 1'b0);

    // Hold with en low
    set_data(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
    sel = 3'd2; step(); chk_all("hold_cap", 4'd2, 1'b1, 1'b0);
    en = 1'b0; sel = 3'd4; data2 = 4'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("hold", 4'd2, 1'b1, 1'b0);
    end
    en = 1'b1; step(); chk_all("hold_rel", 4'd4, 1'b1, 1'b0);

    // Held error flag across en low
    sel = 3'd7; step(); chk_all("err_cap", 4'd0, 1'b0, 1'b1);
    en = 1'b0; sel = 3'd1; step(); chk_all("err_hold", 4'd0, 1'b0, 1'b1);
    en = 1'b1;

    // Latency and data tracking
    data2 = 4'd2;
    sel = 3'd3; step(); chk_all("lat_a", 4'd3, 1'b1, 1'b0);
    data3 = 4'd7;
    #3; chk("lat_mid.out", 32'(out), 32'd3);
    step(); chk_all("lat_b", 4'd7, 1'b1, 1'b0);

    // Simultaneous sel and data change before one edge
    sel = 3'd0; data0 = 4'hA; step(); chk_all("simul", 4'hA, 1'b1, 1'b0);
    data0 = 4'd0;

    // Reset mid-cycle with out previously 3, spanning an edge
    data3 = 4'd3;
    sel = 3'd3; step(); chk_all("pre_rst", 4'd3, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1; chk_all("async_rst", 4'd0, 1'b0, 1'b0);
    step(); chk_all("rst_span", 4'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    // Reset pulse of half a cycle during a sel=1 sweep
    sel = 3'd1; step(); chk_all("sweep1_a", 4'd1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1; chk_all("mid_rst", 4'd0, 1'b0, 1'b0);
    #4 rst_n = 1'b1;
    #1; chk_all("mid_rel", 4'd0, 1'b0, 1'b0);
    step(); chk_all("sweep1_b", 4'd1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
